wb_arb_keybank: RTL and testbench

Parametrised successor of the three-master RAM front end. It arbitrates NM Wishbone B3 masters onto one shared slave port (the on-chip RAM) using fair round-robin. It decodes a memory-mapped key-register window that drives NK 128-bit key outputs, so that window is no longer tied to zero. A per-transfer watchdog terminates stalled slave accesses with an error.

---
 rtl/wb_arb_keybank_pkg.sv | 17 +
 rtl/wb_rr_arbiter.sv | 33 +++
 rtl/wb_arb_keybank.sv | 190 +++++++++++++++++++
 tb/tb_wb_arb_keybank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_keybank_pkg.sv
// Shared types and constants for the wb_arb_keybank RAM/key-bank front end.
package wb_arb_keybank_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int unsigned KEY_BYTES     = 16;
  localparam int unsigned KEY_BITS      = 128;
  localparam int unsigned KEY_WORD_BITS = 32;

  function automatic int unsigned key_window_bytes(input int unsigned nk);
    return nk * KEY_BYTES;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin one-hot grant: first requester strictly after `last` in cyclic order.
module wb_rr_arbiter #(
  parameter int unsigned NM = 3
) (
  input  logic [NM-1:0] req_i,
  input  logic [NM-1:0] last_i,
  output logic [NM-1:0] gnt_c_o
);

  localparam int unsigned IW = $clog2(NM);

  int unsigned last_idx;
  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_c_o  = '0;
    last_idx = 0;
    idx      = 0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (last_i[i]) last_idx = i;
    end
    for (int unsigned off = 1; off <= NM; off++) begin
      idx = (last_idx + off) % NM;
      if (!found && req_i[IW'(idx)]) begin
        gnt_c_o[IW'(idx)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arb_keybank.sv
// NM-master Wishbone round-robin arbiter in front of a RAM slave, with a key-register
// window and a stall watchdog. Define KEYBANK_READBACK_EN to make key words readable.
module wb_arb_keybank
  import wb_arb_keybank_pkg::*;
#(
  parameter int unsigned NM       = 3,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 32,
  parameter int unsigned NK       = 6,
  parameter logic [31:0] KEY_BASE = 32'h0008_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM*AW-1:0]   wbm_adr_i,
  input  logic [NM*DW-1:0]   wbm_dat_i,
  input  logic [NM*4-1:0]    wbm_sel_i,
  input  logic [NM*3-1:0]    wbm_cti_i,
  input  logic [NM*2-1:0]    wbm_bte_i,
  input  logic [NM-1:0]      wbm_cyc_i,
  input  logic [NM-1:0]      wbm_stb_i,
  input  logic [NM-1:0]      wbm_we_i,
  output logic [DW-1:0]      wbm_dat_o,
  output logic [NM-1:0]      wbm_ack_o,
  output logic [NM-1:0]      wbm_err_o,
  output logic [NM-1:0]      wbm_rty_o,
  output logic [AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [3:0]         wbs_sel_o,
  output logic [2:0]         wbs_cti_o,
  output logic [1:0]         wbs_bte_o,
  output logic               wbs_cyc_o,
  output logic               wbs_stb_o,
  output logic               wbs_we_o,
  input  logic [DW-1:0]      wbs_dat_i,
  input  logic               wbs_ack_i,
  input  logic               wbs_err_i,
  output logic [NK*128-1:0]  key_o
);

  localparam int unsigned KIW  = (NK > 1) ? $clog2(NK) : 1;
  localparam logic [AW-1:0] BASE = AW'(KEY_BASE);
  localparam logic [AW-1:0] WIN  = AW'(key_window_bytes(NK));

  arb_state_e          state_q;
  logic [NM-1:0]       grant_q, last_q, arb_gnt;
  logic [NM-1:0]       key_ack_q;
  logic [NK*128-1:0]   key_q, key_d;
  logic [15:0]         wd_q, wd_d;
  logic [DW-1:0]       key_rdat;

  logic [AW-1:0] adr_g, key_off;
  logic [DW-1:0] dat_g;
  logic [3:0]    sel_g;
  logic [2:0]    cti_g;
  logic [1:0]    bte_g;
  logic          cyc_g, stb_g, we_g, own, key_hit_c, key_req, slave_act, stalled, wd_fire_c;
  logic [KIW-1:0] key_idx;
  logic [1:0]    key_word;
  int unsigned   kbit;

  wb_rr_arbiter #(.NM(NM)) u_arb (
    .req_i   (wbm_cyc_i),
    .last_i  (last_q),
    .gnt_c_o (arb_gnt)
  );

  // Select the granted master's request fields (AND-OR mux on one-hot grant).
  always_comb begin
    adr_g = '0;
    dat_g = '0;
    sel_g = '0;
    cti_g = '0;
    bte_g = '0;
    for (int m = 0; m < NM; m++) begin
      if (grant_q[m]) begin
        adr_g = adr_g | wbm_adr_i[m*AW +: AW];
        dat_g = dat_g | wbm_dat_i[m*DW +: DW];
        sel_g = sel_g | wbm_sel_i[m*4 +: 4];
        cti_g = cti_g | wbm_cti_i[m*3 +: 3];
        bte_g = bte_g | wbm_bte_i[m*2 +: 2];
      end
    end
  end

  assign cyc_g     = |(wbm_cyc_i & grant_q);
  assign stb_g     = |(wbm_stb_i & grant_q);
  assign we_g      = |(wbm_we_i & grant_q);
  assign own       = (state_q == ST_OWN);
  assign key_off   = adr_g - BASE;
  assign key_hit_c = own && (adr_g >= BASE) && (key_off < WIN);
  assign key_idx   = KIW'(key_off >> 4);
  assign key_word  = key_off[3:2];
  assign kbit      = KEY_BITS * 32'(key_idx) + KEY_WORD_BITS * 32'(key_word);
  assign key_req   = key_hit_c && cyc_g && stb_g && !(|key_ack_q);
  assign slave_act = own && !key_hit_c && cyc_g && stb_g;
  assign stalled   = slave_act && !wbs_ack_i && !wbs_err_i;
  assign wd_fire_c = stalled && (wd_q == 16'(TIMEOUT - 1));
  assign wd_d      = (stalled && !wd_fire_c) ? wd_q + 16'd1 : 16'd0;

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    if (own && !key_hit_c) begin
      wbs_adr_o = adr_g;
      wbs_dat_o = dat_g;
      wbs_sel_o = sel_g;
      wbs_cti_o = cti_g;
      wbs_bte_o = bte_g;
      wbs_cyc_o = cyc_g;
      wbs_stb_o = stb_g;
      wbs_we_o  = we_g;
    end
  end

  // Byte-masked key write, taken on the same edge that raises ack.
  always_comb begin
    key_d = key_q;
    if (key_req && we_g) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_g[b]) key_d[kbit + 32'(b*8) +: 8] = dat_g[b*8 +: 8];
      end
    end
  end

`ifdef KEYBANK_READBACK_EN
  logic [DW-1:0] key_rdat_q;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)     key_rdat_q <= '0;
    else if (key_req) key_rdat_q <= key_q[kbit +: 32];
  end
  assign key_rdat = key_rdat_q;
`else
  assign key_rdat = '0;
`endif

  // Arbiter FSM: one dead IDLE cycle between ownerships.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(NM-1){1'b0}}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|wbm_cyc_i) begin
            grant_q <= arb_gnt;
            last_q  <= arb_gnt;
            state_q <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!cyc_g) begin
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      key_q     <= '0;
      key_ack_q <= '0;
      wd_q      <= '0;
    end else begin
      key_q     <= key_d;
      key_ack_q <= key_req ? grant_q : '0;
      wd_q      <= wd_d;
    end
  end

  assign key_o     = key_q;
  assign wbm_dat_o = key_hit_c ? key_rdat : wbs_dat_i;
  assign wbm_ack_o = (grant_q & {NM{slave_act && wbs_ack_i}}) | key_ack_q;
  assign wbm_err_o = grant_q & {NM{slave_act && (wbs_err_i || wd_fire_c)}};
  assign wbm_rty_o = '0;

endmodule

// File: tb/tb_wb_arb_keybank.sv
// Directed, table-driven bench for wb_arb_keybank (NM=3, NK=6, TIMEOUT=8).
module tb_wb_arb_keybank;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned NK = 6;
  localparam logic [31:0] KB = 32'h0008_0000;

`ifdef KEYBANK_READBACK_EN
  localparam logic [31:0] RB_BEEF = 32'h0000_BEEF;
`else
  localparam logic [31:0] RB_BEEF = 32'h0000_0000;
`endif

  logic              clk, rst;
  logic [NM*AW-1:0]  wbm_adr;
  logic [NM*32-1:0]  wbm_dat;
  logic [NM*4-1:0]   wbm_sel;
  logic [NM*3-1:0]   wbm_cti;
  logic [NM*2-1:0]   wbm_bte;
  logic [NM-1:0]     wbm_cyc, wbm_stb, wbm_we;
  logic [31:0]       wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [31:0]       wbs_dat_o, wbs_dat_i;
  logic [3:0]        wbs_sel_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i, wbs_err_i;
  logic [NK*128-1:0] key_o;
  logic              slave_en;

  int total = 0;
  int bad   = 0;

  wb_arb_keybank #(.NM(NM), .DW(32), .AW(AW), .NK(NK), .KEY_BASE(KB), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_i(wbm_sel),
    .wbm_cti_i(wbm_cti), .wbm_bte_i(wbm_bte),
    .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb), .wbm_we_i(wbm_we),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .key_o(key_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: zero-wait ack when enabled, read data derived from the address.
  assign wbs_ack_i = slave_en & wbs_cyc_o & wbs_stb_o;
  assign wbs_dat_i = wbs_adr_o ^ 32'hA5A5_5A5A;
  assign wbs_err_i = 1'b0;

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        key;
    logic        chk_rd;
    logic [31:0] rdat;
    int          kk;
    int          kw;
    logic [31:0] kexp;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    wbm_cyc[m]          = cyc;
    wbm_stb[m]          = cyc;
    wbm_we[m]           = we;
    wbm_adr[m*AW +: AW] = adr;
    wbm_dat[m*32 +: 32] = dat;
    wbm_sel[m*4 +: 4]   = sel;
  endtask

  function automatic logic [31:0] kword(input int k, input int w);
    return key_o[k*128 + w*32 +: 32];
  endfunction

  task automatic run_vec(input vec_t v);
    logic got, saw_slave;
    logic [31:0] rd;
    logic [NM-1:0] ackv;
    got = 1'b0; saw_slave = 1'b0; rd = '0; ackv = '0;
    set_m(v.m, 1'b1, v.we, v.adr, v.dat, v.sel);
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (wbs_cyc_o) saw_slave = 1'b1;
      if (wbm_ack_o[v.m]) begin
        got  = 1'b1;
        rd   = wbm_dat_o;
        ackv = wbm_ack_o;
      end
    end
    check("vec_ack_seen", 32'(got), 32'd1);
    check("vec_slave_path", 32'(saw_slave), 32'(!v.key));
    check("vec_ack_onehot", 32'(ackv), 32'(NM'(1) << v.m));
    if (v.chk_rd) check("vec_rdata", rd, v.rdat);
    if (v.key) begin
      @(posedge clk); #1;
      check("vec_ack_pulse", 32'(wbm_ack_o[v.m]), 32'd0);
    end
    set_m(v.m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    check("vec_key_word", kword(v.kk, v.kw), v.kexp);
    @(posedge clk); #1;
  endtask

  // Stalled RAM read; optionally the slave acks on the TIMEOUT-th stalled cycle instead.
  task automatic wd_run(input int m, input int ack_at);
    logic [NM-1:0] exp_err;
    slave_en = 1'b0;
    set_m(m, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i == ack_at) begin slave_en = 1'b1; #1; end
      exp_err = (ack_at < 0 && i == 7) ? NM'(1) << m : '0;
      check("wd_err", 32'(wbm_err_o), 32'(exp_err));
      if (i == ack_at) check("wd_ack_wins", 32'(wbm_ack_o), 32'(NM'(1) << m));
      if (wbm_err_o[m] || i == ack_at) begin
        set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slave_en = 1'b0;
      end
    end
    set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    slave_en = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [NM-1:0] rr_ack[6];
  logic [31:0]   rr_adr[6];

  initial begin
    vt[0] = '{m:1, we:1, adr:KB+32'h14, dat:32'hDEADBEEF, sel:4'b0011, key:1, chk_rd:0, rdat:0, kk:1, kw:1, kexp:32'h0000BEEF};
    vt[1] = '{m:0, we:0, adr:KB+32'h14, dat:32'h0, sel:4'hF, key:1, chk_rd:1, rdat:RB_BEEF, kk:1, kw:1, kexp:32'h0000BEEF};
    vt[2] = '{m:2, we:1, adr:KB+32'h5C, dat:32'h12345678, sel:4'hF, key:1, chk_rd:0, rdat:0, kk:5, kw:3, kexp:32'h12345678};
    vt[3] = '{m:1, we:1, adr:KB+32'h5C, dat:32'hAABBCCDD, sel:4'b1000, key:1, chk_rd:0, rdat:0, kk:5, kw:3, kexp:32'hAA345678};
    vt[4] = '{m:0, we:1, adr:KB+32'h60, dat:32'hFFFFFFFF, sel:4'hF, key:0, chk_rd:0, rdat:0, kk:5, kw:3, kexp:32'hAA345678};
    vt[5] = '{m:2, we:0, adr:32'h0000_1000, dat:32'h0, sel:4'hF, key:0, chk_rd:1, rdat:32'hA5A54A5A, kk:0, kw:0, kexp:32'h0};
    vt[6] = '{m:0, we:1, adr:KB-32'h4, dat:32'h11111111, sel:4'hF, key:0, chk_rd:0, rdat:0, kk:0, kw:3, kexp:32'h0};
    vt[7] = '{m:1, we:0, adr:KB, dat:32'h0, sel:4'hF, key:1, chk_rd:1, rdat:32'h0, kk:0, kw:0, kexp:32'h0};
    rr_ack = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    rr_adr = '{32'h100, 32'h0, 32'h200, 32'h0, 32'h300, 32'h0};

    rst = 1'b1; slave_en = 1'b1;
    wbm_adr = '0; wbm_dat = '0; wbm_sel = '0; wbm_cti = '0; wbm_bte = '0;
    wbm_cyc = '0; wbm_stb = '0; wbm_we = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wbs_cyc", 32'(wbs_cyc_o), 32'd0);
    check("rst_key_zero", 32'(|key_o), 32'd0);
    check("rst_ack_err", 32'({wbm_ack_o, wbm_err_o}), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Three simultaneous requesters: grants 0,1,2 with a dead cycle between each.
    for (int m = 0; m < 3; m++) set_m(m, 1'b1, 1'b0, 32'(32'h100 * (m + 1)), 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("rr_ack", 32'(wbm_ack_o), 32'(rr_ack[i]));
      check("rr_adr", wbs_adr_o, rr_adr[i]);
      for (int m = 0; m < 3; m++)
        if (wbm_ack_o[m]) set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    for (int m = 0; m < 3; m++) set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    wd_run(2, -1);
    wd_run(0, 7);

    // Reset while master 1 owns the bus.
    slave_en = 1'b0;
    set_m(1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("own_before_rst", 32'(wbs_cyc_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_key", 32'(|key_o), 32'd0);
    check("rst_mid_cyc", 32'(wbs_cyc_o), 32'd0);
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    set_m(2, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cyc", 32'(wbs_cyc_o), 32'd1);
    check("post_rst_m0_wins", wbs_adr_o, 32'h0000_0100);
    for (int m = 0; m < 3; m++) set_m(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
